// File: rtl/data_bus_master.sv
// Initiator for the shared 32-bit data bus: word-aligned load/store cycles with
// sub-word extraction. Define LSU_SUBWORD_STORE_EN to enable read-modify-write byte/half stores.
module data_bus_master #(
    parameter int READ_WAIT = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_misaligned,
    output logic [31:0] data_bus_addr,
    output logic [1:0]  data_bus_mode,
    inout  wire  [31:0] data_bus_data
);

    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

`ifdef LSU_SUBWORD_STORE_EN
    localparam bit SUBWORD_ST = 1'b1;
`else
    localparam bit SUBWORD_ST = 1'b0;
`endif

    state_t      state, state_nxt;
    logic [1:0]  lat_size;
    logic        lat_unsigned;
    logic [31:0] lat_addr;
    logic [31:0] wr_word;
    logic [3:0]  wait_cnt;
    logic        req_bad;
`ifdef LSU_SUBWORD_STORE_EN
    logic        lat_write;
`endif

    function automatic logic [31:0] extract(input logic [31:0] word, input logic [1:0] size,
                                            input logic [1:0] off, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{off, 3'b000} +: 8];
        h = word[{off[1], 4'b0000} +: 16];
        case (size)
            SZ_BYTE: extract = uns ? {24'h0, b} : {{24{b[7]}}, b};
            SZ_HALF: extract = uns ? {16'h0, h} : {{16{h[15]}}, h};
            default: extract = word;
        endcase
    endfunction

`ifdef LSU_SUBWORD_STORE_EN
    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [1:0] size, input logic [1:0] off);
        merge = old;
        if (size == SZ_BYTE)
            merge[{off, 3'b000} +: 8] = wd[7:0];
        else
            merge[{off[1], 4'b0000} +: 16] = wd[15:0];
    endfunction
`endif

    // Rejected requests: bad alignment, illegal size, or sub-word store without RMW support.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        req_bad = 1'b0;
        case (req_size)
            SZ_BYTE: req_bad = req_write && !SUBWORD_ST;
            SZ_HALF: req_bad = req_addr[0] || (req_write && !SUBWORD_ST);
            SZ_WORD: req_bad = |req_addr[1:0];
            default: req_bad = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses <= so all registers update from pre-edge values.
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (req_bad)
                        state_nxt = DONE;
                    else if (req_write && req_size == SZ_WORD)
                        state_nxt = WR;
                    else
                        state_nxt = RD;
                end
            end
            RD: begin
                if (wait_cnt == 4'd0) begin
`ifdef LSU_SUBWORD_STORE_EN
                    state_nxt = lat_write ? WR : DONE;
`else
                    state_nxt = DONE;
`endif
                end
            end
            WR:      state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lat_size        <= 2'b00;
            lat_unsigned    <= 1'b0;
            lat_addr        <= 32'h0;
            wr_word         <= 32'h0;
            wait_cnt        <= 4'd0;
            resp_rdata      <= 32'h0;
            resp_misaligned <= 1'b0;
`ifdef LSU_SUBWORD_STORE_EN
            lat_write       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        lat_size     <= req_size;
                        lat_unsigned <= req_unsigned;
                        lat_addr     <= req_addr;
                        wr_word      <= req_wdata;
                        wait_cnt     <= 4'(READ_WAIT);
`ifdef LSU_SUBWORD_STORE_EN
                        lat_write    <= req_write;
`endif
                        if (req_bad) begin
                            resp_rdata      <= 32'h0;
                            resp_misaligned <= 1'b1;
                        end
                    end
                end
                RD: begin
                    if (wait_cnt != 4'd0) begin
                        wait_cnt <= wait_cnt - 4'd1;
`ifdef LSU_SUBWORD_STORE_EN
                    end else if (lat_write) begin
                        wr_word <= merge(data_bus_data, wr_word, lat_size, lat_addr[1:0]);
`endif
                    end else begin
                        resp_rdata      <= extract(data_bus_data, lat_size, lat_addr[1:0], lat_unsigned);
                        resp_misaligned <= 1'b0;
                    end
                end
                WR: begin
                    resp_rdata      <= 32'h0;
                    resp_misaligned <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Bus outputs decode straight from state so an async reset releases the bus at once.
    assign req_ready     = (state == IDLE);
    assign resp_valid    = (state == DONE);
    assign data_bus_mode = (state == RD) ? 2'b01 : (state == WR) ? 2'b10 : 2'b00;
    assign data_bus_addr = (state == RD || state == WR) ? {lat_addr[31:2], 2'b00} : 32'h0;
    assign data_bus_data = (state == WR) ? wr_word : 32'hzzzz_zzzz;

endmodule

// File: tb/tb_data_bus_master.sv
// Directed bench for data_bus_master: two instances (READ_WAIT 0 and 3) on private buses
// sharing one read-only responder image; expectations go through a scoreboard queue.
module tb_data_bus_master;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        req_valid [2];
    logic        req_ready [2];
    logic        resp_valid [2];
    logic [31:0] resp_rdata [2];
    logic        resp_mis [2];
    logic [31:0] bus_addr [2];
    logic [1:0]  mode [2];
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    wire  [31:0] bus_d0;
    wire  [31:0] bus_d1;
    logic [31:0] rsp0, rsp1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        mis;
        int          lat;
        int          n_rd;
        int          n_wr;
        logic [31:0] addr;
        logic [31:0] wdata;
    } exp_t;

    exp_t sb[$];

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        case (a)
            32'h0000_4030: mem_rd = 32'h0000_002A;
            32'h0000_1000: mem_rd = 32'h80FF_7F01;
            32'h0000_2004: mem_rd = 32'h1122_3344;
            default:       mem_rd = 32'h0;
        endcase
    endfunction

    always_comb rsp0 = mem_rd(bus_addr[0]);
    always_comb rsp1 = mem_rd(bus_addr[1]);
    assign bus_d0 = (mode[0] == 2'b01) ? rsp0 : 32'hzzzz_zzzz;
    assign bus_d1 = (mode[1] == 2'b01) ? rsp1 : 32'hzzzz_zzzz;

    data_bus_master #(.READ_WAIT(0)) u_dut0 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid[0]), .resp_rdata(resp_rdata[0]), .resp_misaligned(resp_mis[0]),
        .data_bus_addr(bus_addr[0]), .data_bus_mode(mode[0]), .data_bus_data(bus_d0)
    );

    data_bus_master #(.READ_WAIT(3)) u_dut3 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid[1]), .resp_rdata(resp_rdata[1]), .resp_misaligned(resp_mis[1]),
        .data_bus_addr(bus_addr[1]), .data_bus_mode(mode[1]), .data_bus_data(bus_d1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Released bus reads as Z in a 4-state simulator and as 0 in a 2-state one.
    function automatic logic bus_released(input logic [31:0] v);
        return (v === 32'hzzzz_zzzz) || (v === 32'h0);
    endfunction

    function automatic logic [31:0] bus_data(input int sel);
        return (sel == 1) ? bus_d1 : bus_d0;
    endfunction

    function automatic exp_t ex(input logic [31:0] rdata, input logic mis, input int lat,
                                input int n_rd, input int n_wr, input logic [31:0] addr,
                                input logic [31:0] wdata);
        exp_t e;
        e.rdata = rdata; e.mis = mis; e.lat = lat; e.n_rd = n_rd;
        e.n_wr = n_wr; e.addr = addr; e.wdata = wdata;
        return e;
    endfunction

    function automatic exp_t ex_mis();
        return ex(32'h0, 1'b1, 1, 0, 0, 32'h0, 32'h0);
    endfunction

    task automatic run_req(input int sel, input logic wr, input logic [1:0] sz, input logic uns,
                           input logic [31:0] a, input logic [31:0] wd, input exp_t e,
                           input string tag);
        exp_t        x;
        int          n_rd = 0;
        int          n_wr = 0;
        int          lat = 0;
        logic        got = 1'b0;
        logic        mis = 1'b0;
        logic [31:0] rd = 32'h0;
        logic [31:0] seen_addr = 32'h0;
        logic [31:0] seen_wdata = 32'h0;
        sb.push_back(e);
        @(negedge clk);
        req_valid[sel] = 1'b1;
        req_write = wr; req_size = sz; req_unsigned = uns; req_addr = a; req_wdata = wd;
        @(posedge clk); #1;
        // Scramble request fields after the accept edge; the DUT must use its latched copy.
        req_valid[sel] = 1'b0;
        req_write = ~wr; req_size = ~sz; req_unsigned = ~uns; req_addr = ~a; req_wdata = ~wd;
        for (int k = 1; k <= 40; k++) begin
            if (mode[sel] == 2'b01) begin
                n_rd++;
                seen_addr = bus_addr[sel];
            end
            if (mode[sel] == 2'b10) begin
                n_wr++;
                seen_addr = bus_addr[sel];
                seen_wdata = bus_data(sel);
            end
            if (resp_valid[sel]) begin
                got = 1'b1; lat = k; rd = resp_rdata[sel]; mis = resp_mis[sel];
                break;
            end
            @(posedge clk); #1;
        end
        x = sb.pop_front();
        chk({tag, "/resp_seen"}, 32'(got), 32'd1);
        chk({tag, "/latency"}, 32'(lat), 32'(x.lat));
        chk({tag, "/rdata"}, rd, x.rdata);
        chk({tag, "/misaligned"}, 32'(mis), 32'(x.mis));
        chk({tag, "/rd_cycles"}, 32'(n_rd), 32'(x.n_rd));
        chk({tag, "/wr_cycles"}, 32'(n_wr), 32'(x.n_wr));
        chk({tag, "/bus_addr"}, seen_addr, x.addr);
        chk({tag, "/bus_wdata"}, seen_wdata, x.wdata);
        @(posedge clk); #1;
        chk({tag, "/ready_after"}, 32'(req_ready[sel]), 32'd1);
        chk({tag, "/valid_after"}, 32'(resp_valid[sel]), 32'd0);
        chk({tag, "/rdata_hold"}, resp_rdata[sel], x.rdata);
        chk({tag, "/mode_after"}, 32'(mode[sel]), 32'd0);
        chk({tag, "/bus_z_after"}, 32'(bus_released(bus_data(sel))), 32'd1);
    endtask

    initial begin
        int n_valid;
        int n_wr;
        reset = 1'b1;
        req_valid[0] = 1'b0; req_valid[1] = 1'b0;
        req_write = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0;
        #12;
        chk("rst/ready", 32'(req_ready[0]), 32'd1);
        chk("rst/valid", 32'(resp_valid[0]), 32'd0);
        chk("rst/rdata", resp_rdata[0], 32'h0);
        chk("rst/mis", 32'(resp_mis[0]), 32'd0);
        chk("rst/mode", 32'(mode[0]), 32'd0);
        chk("rst/addr", bus_addr[0], 32'h0);
        chk("rst/bus_z", 32'(bus_released(bus_d0)), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;

        // READ_WAIT = 0 instance
        run_req(0, 1'b0, 2'b10, 1'b0, 32'h0000_4030, 32'h0, ex(32'h0000_002A, 1'b0, 2, 1, 0, 32'h4030, 32'h0), "ld_w_systick");
        run_req(0, 1'b0, 2'b00, 1'b0, 32'h0000_1003, 32'h0, ex(32'hFFFF_FF80, 1'b0, 2, 1, 0, 32'h1000, 32'h0), "ld_b_s_1003");
        run_req(0, 1'b0, 2'b00, 1'b1, 32'h0000_1003, 32'h0, ex(32'h0000_0080, 1'b0, 2, 1, 0, 32'h1000, 32'h0), "ld_b_u_1003");
        run_req(0, 1'b0, 2'b00, 1'b0, 32'h0000_1001, 32'h0, ex(32'h0000_007F, 1'b0, 2, 1, 0, 32'h1000, 32'h0), "ld_b_s_1001");
        run_req(0, 1'b0, 2'b01, 1'b1, 32'h0000_1000, 32'h0, ex(32'h0000_7F01, 1'b0, 2, 1, 0, 32'h1000, 32'h0), "ld_h_u_1000");
        run_req(0, 1'b0, 2'b01, 1'b0, 32'h0000_1002, 32'h0, ex(32'hFFFF_80FF, 1'b0, 2, 1, 0, 32'h1000, 32'h0), "ld_h_s_1002");
        run_req(0, 1'b0, 2'b01, 1'b0, 32'h0000_3001, 32'h0, ex_mis(), "mis_ld_h_3001");
        run_req(0, 1'b0, 2'b10, 1'b0, 32'h0000_3002, 32'h0, ex_mis(), "mis_ld_w_3002");
        run_req(0, 1'b0, 2'b11, 1'b0, 32'h0000_3000, 32'h0, ex_mis(), "mis_size11");
        run_req(0, 1'b1, 2'b10, 1'b0, 32'h0000_2002, 32'h1234_5678, ex_mis(), "mis_st_w_2002");
        run_req(0, 1'b1, 2'b10, 1'b0, 32'h0000_2000, 32'hDEAD_BEEF, ex(32'h0, 1'b0, 2, 0, 1, 32'h2000, 32'hDEAD_BEEF), "st_w_2000");
`ifdef LSU_SUBWORD_STORE_EN
        run_req(0, 1'b1, 2'b00, 1'b0, 32'h0000_2005, 32'h1234_56AB, ex(32'h0, 1'b0, 3, 1, 1, 32'h2004, 32'h1122_AB44), "st_b_2005");
        run_req(0, 1'b1, 2'b01, 1'b0, 32'h0000_2006, 32'h9999_BEEF, ex(32'h0, 1'b0, 3, 1, 1, 32'h2004, 32'hBEEF_3344), "st_h_2006");
`else
        run_req(0, 1'b1, 2'b00, 1'b0, 32'h0000_2005, 32'h1234_56AB, ex_mis(), "st_b_2005");
        run_req(0, 1'b1, 2'b01, 1'b0, 32'h0000_2006, 32'h9999_BEEF, ex_mis(), "st_h_2006");
`endif

        // READ_WAIT = 3 instance
        run_req(1, 1'b0, 2'b10, 1'b0, 32'h0000_4030, 32'h0, ex(32'h0000_002A, 1'b0, 5, 4, 0, 32'h4030, 32'h0), "w3_ld_w");
        run_req(1, 1'b0, 2'b00, 1'b1, 32'h0000_1000, 32'h0, ex(32'h0000_0001, 1'b0, 5, 4, 0, 32'h1000, 32'h0), "w3_ld_b_u");
        run_req(1, 1'b0, 2'b10, 1'b0, 32'h0000_3002, 32'h0, ex_mis(), "w3_mis_ld_w");
        run_req(1, 1'b1, 2'b10, 1'b0, 32'h0000_2000, 32'hCAFE_F00D, ex(32'h0, 1'b0, 2, 0, 1, 32'h2000, 32'hCAFE_F00D), "w3_st_w");
`ifdef LSU_SUBWORD_STORE_EN
        run_req(1, 1'b1, 2'b00, 1'b0, 32'h0000_2004, 32'h0000_00CD, ex(32'h0, 1'b0, 6, 4, 1, 32'h2004, 32'h1122_33CD), "w3_st_b");
`else
        run_req(1, 1'b1, 2'b00, 1'b0, 32'h0000_2004, 32'h0000_00CD, ex_mis(), "w3_st_b");
`endif

        // Reset in the middle of a read phase: bus released at once, no write, no response.
        @(negedge clk);
        req_valid[1] = 1'b1;
`ifdef LSU_SUBWORD_STORE_EN
        req_write = 1'b1; req_size = 2'b00; req_unsigned = 1'b0; req_addr = 32'h2005; req_wdata = 32'hAB;
`else
        req_write = 1'b0; req_size = 2'b10; req_unsigned = 1'b0; req_addr = 32'h4030; req_wdata = 32'h0;
`endif
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        @(posedge clk); #1;
        chk("rstmid/mode_rd", 32'(mode[1]), 32'd1);
        reset = 1'b1;
        #1;
        chk("rstmid/mode_now", 32'(mode[1]), 32'd0);
        chk("rstmid/addr_now", bus_addr[1], 32'h0);
        chk("rstmid/bus_z_now", 32'(bus_released(bus_d1)), 32'd1);
        @(posedge clk); #1;
        reset = 1'b0;
        n_valid = 0;
        n_wr = 0;
        for (int k = 0; k < 10; k++) begin
            if (resp_valid[1]) n_valid++;
            if (mode[1] == 2'b10) n_wr++;
            @(posedge clk); #1;
        end
        chk("rstmid/no_resp", 32'(n_valid), 32'd0);
        chk("rstmid/no_write", 32'(n_wr), 32'd0);
        chk("rstmid/ready", 32'(req_ready[1]), 32'd1);
        chk("rstmid/rdata_clr", resp_rdata[1], 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_bus_master.md
Name: data_bus_master

Overview:
- Initiator side of the shared 32-bit data bus (addr / bidirectional data / 2-bit mode).
- Accepts load/store requests from the core and runs word-aligned bus cycles.
- Performs byte/half extraction with sign or zero extension; sub-word stores use read-modify-write.
- Sits between the core's memory stage and all bus responders (RAM, systick at 0x4030, other MMIO).

Parameters:
- READ_WAIT, 0: extra cycles data_bus_mode=01 is held before read data is sampled (0..15).

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-high reset
- req_valid  input  1  core request present
- req_ready  output  1  block can accept a request (IDLE only)
- req_write  input  1  1=store, 0=load
- req_size  input  2  00 byte, 01 half, 10 word, 11 illegal
- req_unsigned  input  1  loads: 1=zero-extend, 0=sign-extend
- req_addr  input  32  byte address
- req_wdata  input  32  store data, right-aligned
- resp_valid  output  1  one-cycle completion pulse
- resp_rdata  output  32  extended load data; 0 for stores and errors
- resp_misaligned  output  1  qualifies resp_valid: request rejected, no bus traffic
- data_bus_addr  output  32  word address {addr[31:2],2'b00}; 0 when not in a bus cycle
- data_bus_mode  output  2  00 idle, 01 read, 10 write
- data_bus_data  inout  32  driven only while mode=10, else high-Z

Behaviour:
- States: IDLE, RD, WR, DONE.
- Accept on a rising edge with req_valid && req_ready. All request fields are latched; later changes on req_* are ignored.
- Misaligned request: half with addr[0]=1, word with addr[1:0]!=0, or size 11.
  - IDLE -> DONE with resp_misaligned=1.
  - Bus stays 00 / Z.
- Load: IDLE -> RD -> DONE.
  - RD holds mode=01 for READ_WAIT+1 cycles.
  - data_bus_data is sampled at the edge ending the last RD cycle.
- Word store: IDLE -> WR -> DONE.
  - WR lasts exactly one cycle: mode=10, data_bus_data=req_wdata.
- Byte/half store: IDLE -> RD -> WR -> DONE.
  - The read word is merged with the selected lane(s) of req_wdata: byte lane = addr[1:0], half lane = addr[1].
  - The merged word is written back.
- Latency, accept edge at end of cycle T, W=READ_WAIT:
  - Load: resp_valid in cycle T+2+W.
  - Word store: resp_valid in cycle T+2.
  - Sub-word store: resp_valid in cycle T+3+W.
  - Misaligned: resp_valid in cycle T+1.
- DONE lasts one cycle: resp_valid=1, then -> IDLE with req_ready=1 the following cycle. There are no back-to-back accepts.
- Load extraction:
  - Byte = word[8*addr[1:0] +: 8].
  - Half = word[16*addr[1] +: 16].
  - Extended to 32 bits per req_unsigned.
- resp_rdata and resp_misaligned hold their values until the next DONE. Both are 0 after reset.
- Reset values: req_ready=1, resp_valid=0, resp_rdata=0, resp_misaligned=0, mode=00, addr=0, data=Z.
- Reset mid-operation (asserted asynchronously): the bus is released immediately (mode=00, Z), no response is issued, state returns to IDLE. A partially completed RMW is abandoned with no write.
- A high-Z/undriven read (no responder) returns whatever is sampled. No timeout.

Optional Feature:
- LSU_SUBWORD_STORE_EN
  - Defined: byte/half stores use RMW as above.
  - Undefined: the RMW path and merge logic are omitted. Byte/half stores complete as misaligned: DONE in T+1, resp_misaligned=1, no bus traffic. Sub-word loads are unaffected.

Test Plan:
- READ_WAIT=0; responder returns 0x0000_002A at 0x4030; load word addr 0x4030 -> mode=01 addr=0x4030 in T+1; resp_valid in T+2, resp_rdata=0x0000_002A, resp_misaligned=0.
- Responder word 0x80FF_7F01 at 0x1000:
  - load byte 0x1003 signed -> 0xFFFF_FF80.
  - load byte 0x1003 unsigned -> 0x0000_0080.
  - load half 0x1002 signed -> 0xFFFF_80FF.
- Store word 0xDEAD_BEEF to 0x2000 -> single cycle with mode=10, addr=0x2000, data=0xDEAD_BEEF; resp_valid T+2; data Z afterwards.
- RAM word 0x1122_3344 at 0x2004; store byte 0xAB to 0x2005:
  - With LSU_SUBWORD_STORE_EN: RD then WR of 0x1122_AB44; resp_valid T+3.
  - Without it: no bus cycle, resp_misaligned=1 at T+1.
- Load half 0x3001 and load word 0x3002 -> resp_misaligned=1 at T+1, resp_rdata=0, mode stays 00. Repeat with READ_WAIT=3: word load holds mode=01 four cycles, resp_valid T+5.
- Assert reset during RD of a sub-word store -> mode=00 and data Z in the same cycle, no WR cycle, no resp_valid, req_ready=1 after reset release.
